tri_mat_row_loader: RTL and testbench
=====================================

// Module: tri_mat_row_loader
// PURPOSE
//  Upstream feeder of the triangular-matrix inverter. Accepts a lower-triangular complex matrix as a
//  row-major element stream, holds it in a SIZE x SIZE register array (upper triangle forced to zero),
//  pulses start_o once the last element is stored, then serves row reads addressed by the inverter
//  until done_i or flush_i returns it to loading.
// PARAMETERS
//  SIZE   16   matrix dimension N; complex element = 128 b {imag[127:64], real[63:0]}, IEEE-754 binary64
// PORTS
//  clk_i            in   1              clock
//  rst_ni           in   1              asynchronous active-low reset
//  ld_data_i        in   128            complex element {imag,real}
//  ld_valid_i       in   1              element valid
//  ld_ready_o       out  1              element accepted when valid & ready
//  start_o          out  1              one-cycle pulse: matrix complete
//  row_addr_i       in   $clog2(SIZE)   row requested by the inverter
//  row_addr_valid_i in   1              request valid
//  row_o            out  SIZE*128       row contents, element [c] at bits [c*128 +: 128]
//  row_addr_o       out  $clog2(SIZE)   row index that row_o belongs to
//  row_valid_o      out  1              row_o/row_addr_o valid
//  diag_zero_o      out  1              sticky: a diagonal element had real==imag==+/-0
//  done_i           in   1              inverter finished; release the matrix
//  flush_i          in   1              abort; discard contents
//  busy_o           out  1              high whenever state != LOAD or any element is stored
// BEHAVIOUR
//  - Reset (async, rst_ni=0): state=LOAD, row_cnt=col_cnt=0, array cleared to 0, ld_ready_o=1,
//    start_o=0, row_o=0, row_addr_o=0, row_valid_o=0, diag_zero_o=0, busy_o=0.
//  - States:
//      LOAD  -> SERVE  on acceptance of element (row SIZE-1, col SIZE-1)
//      SERVE -> LOAD   on done_i or flush_i
//      LOAD  -> LOAD   on flush_i (counters and array cleared)
//  - LOAD:
//    - ld_ready_o=1. Each accepted element is written to [row_cnt][col_cnt].
//    - col_cnt increments. When col_cnt==row_cnt: col_cnt<=0, row_cnt++.
//    - Exactly SIZE*(SIZE+1)/2 elements form one matrix; upper triangle is never written and stays 0.
//    - row_valid_o=0; read requests are ignored.
//  - Diagonal check: an accepted element with col_cnt==row_cnt and data[126:64]==0 and data[62:0]==0
//    sets diag_zero_o. Only reset, flush or the next LOAD entry clears it. Loading still completes.
//  - start_o: registered, high exactly the cycle after the final element handshake. ld_ready_o=0 from
//    that same cycle.
//  - SERVE read path (one-cycle latency, registered):
//    - If row_addr_valid_i, next cycle row_o<=array[row_addr_i], row_addr_o<=row_addr_i, row_valid_o<=1.
//    - Otherwise row_valid_o<=0 and row_o/row_addr_o hold their values.
//    - There is no back-pressure. The inverter holds row_addr_i until it consumes the matching row.
//    - A request may change every cycle; back-to-back distinct addresses give back-to-back rows.
//  - done_i / flush_i in SERVE:
//    - Next cycle: state=LOAD, row_valid_o=0, counters=0, array cleared, diag_zero_o=0.
//    - ld_ready_o=1 from that cycle.
//  - Precedence (high->low): rst_ni, flush_i, done_i, load handshake, read request.
//    - flush_i on the final-element cycle: element discarded, no start_o.
//    - done_i in LOAD: ignored.
//  - No arithmetic. Element data is stored bit-exact, including NaN payloads and signed zeros.
// STRUCTURE
//  - Shared package matinv_pkg:
//    - typedef logic [127:0] cplx_t
//    - typedef enum logic [0:0] {LOAD, SERVE} loader_state_t
//    - localparam CPLX_W = 128
//  - One sub-module: tri_index_counter (row/col triangular walker with last_o flag), reusable by the
//    inverter-output collector.
//  - Array as flops cplx_t [SIZE-1:0][SIZE-1:0]. Clear is a single-cycle bulk reset of the array.
// TESTING (SIZE=4)
//  1. Load 10 elements:
//     - elements: re=1.0..10.0 (64'h3FF0...), im=0, ld_valid_i held high
//     - ld_ready_o high for exactly 10 cycles
//     - start_o one pulse the cycle after the 10th
//     - array[3]={10,9,8,7}, array[0]={0,0,0,1} (element 0 at LSB)
//  2. SERVE reads:
//     - row_addr_i=2,0,3 on consecutive cycles
//     - row_valid_o on cycles 1..3 with row_addr_o=2,0,3
//     - row 0 upper entries 128'h0, row 2 = {0,6,5,4}
//  3. Diagonal zero:
//     - element (1,1) = {64'h8000_0000_0000_0000, 64'h0}
//     - diag_zero_o rises next cycle, stays high through SERVE, clears on done_i
//  4. ld_valid_i toggled 1,0,1,0... with 20 cycles of random gaps:
//     - exactly 10 handshakes, start_o once
//     - no write on ld_valid_i=0 cycles
//  5. Flush mid-load and mid-serve:
//     - flush_i after 6 elements -> counters 0, next 10 elements form a fresh matrix
//     - flush_i on the final-element cycle -> no start_o
//     - flush_i in SERVE -> row_valid_o=0 next cycle, ld_ready_o=1
//  6. Async reset asserted mid-SERVE between clock edges:
//     - all outputs reach their reset values immediately
//     - after release: LOAD, ld_ready_o=1, reads ignored

Source files
------------

// File: rtl/matinv_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// matinv_pkg : shared types for the triangular-matrix inverter datapath
// Rev 1.0
// -----------------------------------------------------------------------------
package matinv_pkg;

  localparam int CPLX_W = 128;

  typedef logic [CPLX_W-1:0] cplx_t;

  typedef enum logic [0:0] {
    LOAD  = 1'b0,
    SERVE = 1'b1
  } loader_state_t;

  // True when both real and imaginary parts are +0 or -0 (sign bits ignored).
  function automatic logic is_cplx_zero(input cplx_t v);
    return (v[126:64] == '0) && (v[62:0] == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tri_index_counter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tri_index_counter : row-major walker over the lower triangle (col <= row)
// Rev 1.0
// -----------------------------------------------------------------------------
module tri_index_counter #(
  parameter int SIZE = 16,
  parameter int AW   = $clog2(SIZE)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          step_i,
  output logic [AW-1:0] row_o,
  output logic [AW-1:0] col_o,
  output logic          last_o
);

  localparam logic [AW-1:0] LAST_IDX = AW'(SIZE - 1);

  logic [AW-1:0] row_q;
  logic [AW-1:0] col_q;

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = (row_q == LAST_IDX) && (col_q == LAST_IDX);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q <= '0;
      col_q <= '0;
    end else if (clear_i) begin
      row_q <= '0;
      col_q <= '0;
    end else if (step_i) begin
      if (col_q == row_q) begin
        col_q <= '0;
        row_q <= last_o ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tri_mat_row_loader.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tri_mat_row_loader : buffers a streamed lower-triangular complex matrix and
//                      serves registered row reads to the inverter
// Rev 1.0
// -----------------------------------------------------------------------------
module tri_mat_row_loader
  import matinv_pkg::*;
#(
  parameter int SIZE = 16,
  parameter int AW   = $clog2(SIZE)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  cplx_t                  ld_data_i,
  input  logic                   ld_valid_i,
  output logic                   ld_ready_o,
  output logic                   start_o,
  input  logic [AW-1:0]          row_addr_i,
  input  logic                   row_addr_valid_i,
  output logic [SIZE*CPLX_W-1:0] row_o,
  output logic [AW-1:0]          row_addr_o,
  output logic                   row_valid_o,
  output logic                   diag_zero_o,
  input  logic                   done_i,
  input  logic                   flush_i,
  output logic                   busy_o
);

  loader_state_t state_q, state_d;

  cplx_t [SIZE-1:0][SIZE-1:0] mat_q;

  logic [AW-1:0] row_cnt;
  logic [AW-1:0] col_cnt;
  logic          cnt_last;
  logic          accept;
  logic          clear;
  logic          final_elem;

  // flush outranks the handshake, so a flushed element is never stored
  assign accept     = (state_q == LOAD) && ld_valid_i && !flush_i;
  assign clear      = flush_i || ((state_q == SERVE) && done_i);
  assign final_elem = accept && cnt_last;

  assign ld_ready_o = (state_q == LOAD);
  assign busy_o     = (state_q != LOAD) || (row_cnt != '0) || (col_cnt != '0);

  tri_index_counter #(
    .SIZE (SIZE),
    .AW   (AW)
  ) u_idx (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear),
    .step_i  (accept),
    .row_o   (row_cnt),
    .col_o   (col_cnt),
    .last_o  (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = LOAD;
    end else if (final_elem) begin
      state_d = SERVE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mat_q <= '0;
    end else if (clear) begin
      mat_q <= '0;
    end else if (accept) begin
      mat_q[row_cnt][col_cnt] <= ld_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      start_o     <= 1'b0;
      diag_zero_o <= 1'b0;
    end else begin
      start_o <= final_elem;
      if (clear) begin
        diag_zero_o <= 1'b0;
      end else if (accept && (row_cnt == col_cnt) && is_cplx_zero(ld_data_i)) begin
        diag_zero_o <= 1'b1;
      end
    end
  end

  // Read port: row_o/row_addr_o hold their last value when no request is made.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_o       <= '0;
      row_addr_o  <= '0;
      row_valid_o <= 1'b0;
    end else if (clear || (state_q != SERVE)) begin
      row_valid_o <= 1'b0;
    end else if (row_addr_valid_i) begin
      row_o       <= mat_q[row_addr_i];
      row_addr_o  <= row_addr_i;
      row_valid_o <= 1'b1;
    end else begin
      row_valid_o <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tri_mat_row_loader.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_tri_mat_row_loader : randomized self-checking bench with a lower-triangle model
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_tri_mat_row_loader;
  import matinv_pkg::*;

  localparam int SIZE = 4;
  localparam int AW   = 2;
  localparam int NEL  = SIZE * (SIZE + 1) / 2;
  localparam int RW   = SIZE * CPLX_W;

  logic          clk = 1'b0;
  logic          rst_n;
  cplx_t         ld_data;
  logic          ld_valid;
  logic          ld_ready;
  logic          start;
  logic [AW-1:0] row_addr;
  logic          row_addr_valid;
  logic [RW-1:0] row;
  logic [AW-1:0] row_addr_q;
  logic          row_valid;
  logic          diag_zero;
  logic          done;
  logic          flush;
  logic          busy;

  int checks = 0;
  int errors = 0;

  cplx_t         mdl [NEL];
  int            raddr [16];
  logic          cap_v [18];
  logic [AW-1:0] cap_a [18];
  logic [RW-1:0] cap_r [18];

  always #5 clk = ~clk;

  tri_mat_row_loader #(.SIZE(SIZE), .AW(AW)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .ld_data_i        (ld_data),
    .ld_valid_i       (ld_valid),
    .ld_ready_o       (ld_ready),
    .start_o          (start),
    .row_addr_i       (row_addr),
    .row_addr_valid_i (row_addr_valid),
    .row_o            (row),
    .row_addr_o       (row_addr_q),
    .row_valid_o      (row_valid),
    .diag_zero_o      (diag_zero),
    .done_i           (done),
    .flush_i          (flush),
    .busy_o           (busy)
  );

  // Row r holds stream elements r(r+1)/2 .. r(r+1)/2+r; columns above the diagonal are zero.
  function automatic logic [RW-1:0] exp_row(input int r);
    logic [RW-1:0] v;
    v = '0;
    for (int c = 0; c <= r; c++) v[c*CPLX_W +: CPLX_W] = mdl[r*(r+1)/2 + c];
    return v;
  endfunction

  function automatic int first_zero_diag();
    for (int r = 0; r < SIZE; r++) begin
      int k;
      k = r*(r+1)/2 + r;
      if (mdl[k][126:64] == '0 && mdl[k][62:0] == '0) return k;
    end
    return -1;
  endfunction

  task automatic fill_random(input int zero_idx);
    for (int k = 0; k < NEL; k++) begin
      mdl[k]    = {$urandom(), $urandom(), $urandom(), $urandom()};
      mdl[k][0] = 1'b1;
    end
    if (zero_idx >= 0)
      mdl[zero_idx] = {($urandom_range(1) != 0) ? 64'h8000_0000_0000_0000 : 64'h0,
                       ($urandom_range(1) != 0) ? 64'h8000_0000_0000_0000 : 64'h0};
  endtask

  // Streams mdl[first..last_excl-1]; reports handshakes, start pulses and when diag_zero rose.
  task automatic feed(input int first, input int last_excl, input bit gaps,
                      output int hs, output int starts, output int rdy,
                      output int diag_rise, output int start_at);
    int idx, cyc, tail;
    bit pend, prev_v;
    idx = first; cyc = 0; tail = 0; pend = 0; prev_v = 0;
    hs = 0; starts = 0; rdy = 0; diag_rise = -1; start_at = -1;
    while (tail < 3 && cyc < 300) begin
      @(negedge clk);
      if (pend) begin hs++; idx++; end
      if (start === 1'b1) begin starts++; if (start_at < 0) start_at = hs; end
      if (diag_zero === 1'b1 && diag_rise < 0) diag_rise = idx;
      if (ld_ready === 1'b1) rdy++;
      if (idx < last_excl) begin
        if (gaps && (prev_v || $urandom_range(2) == 0)) begin
          ld_valid = 1'b0;
          ld_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        end else begin
          ld_valid = 1'b1;
          ld_data  = mdl[idx];
        end
      end else begin
        ld_valid = 1'b0;
        tail++;
      end
      prev_v = ld_valid;
      pend   = ld_valid && (ld_ready === 1'b1);
      cyc++;
    end
  endtask

  task automatic do_read(input int n);
    for (int j = 0; j <= n + 1; j++) begin
      @(negedge clk);
      cap_v[j] = row_valid;
      cap_a[j] = row_addr_q;
      cap_r[j] = row;
      if (j < n) begin
        row_addr_valid = 1'b1;
        row_addr       = AW'(raddr[j]);
      end else begin
        row_addr_valid = 1'b0;
      end
    end
  endtask

  task automatic release_done();
    @(negedge clk); done = 1'b1;
    @(negedge clk); done = 1'b0;
  endtask

  task automatic check_all_rows(input string tag);
    for (int r = 0; r < SIZE; r++) raddr[r] = r;
    do_read(SIZE);
    for (int r = 0; r < SIZE; r++) begin
      checks++;
      if (cap_v[r+1] !== 1'b1 || cap_r[r+1] !== exp_row(r)) begin
        errors++;
        $display("FAIL %s row%0d: got v=%b %h expected v=1 %h", tag, r, cap_v[r+1], cap_r[r+1], exp_row(r));
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ld_valid = 1'b0; ld_data = '0; row_addr = '0; row_addr_valid = 1'b0;
    done = 1'b0; flush = 1'b0;
    #12;
    checks++;
    if ({ld_ready, start, row_valid, diag_zero, busy} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags: got rdy,start,rv,dz,busy=%b expected 10000", {ld_ready, start, row_valid, diag_zero, busy});
    end
    checks++;
    if (row !== '0 || row_addr_q !== '0) begin
      errors++;
      $display("FAIL reset_row: got addr=%0d row=%h expected 0", row_addr_q, row);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_load_basic();
    int hs, st, rdy, dr, sa;
    for (int k = 0; k < NEL; k++) mdl[k] = {64'h0, $realtobits(real'(k + 1))};
    feed(0, NEL, 1'b0, hs, st, rdy, dr, sa);
    checks++;
    if (hs !== NEL || st !== 1 || sa !== NEL) begin
      errors++;
      $display("FAIL load_handshake: got hs=%0d starts=%0d start_at=%0d expected %0d 1 %0d", hs, st, sa, NEL, NEL);
    end
    checks++;
    if (rdy !== NEL) begin
      errors++;
      $display("FAIL load_ready_cycles: got %0d expected %0d", rdy, NEL);
    end
    checks++;
    if (ld_ready !== 1'b0 || busy !== 1'b1 || dr !== -1) begin
      errors++;
      $display("FAIL serve_flags: got rdy=%b busy=%b diag_rise=%0d expected 0 1 -1", ld_ready, busy, dr);
    end
    raddr[0] = 3; raddr[1] = 0;
    do_read(2);
    for (int c = 0; c < SIZE; c++) begin
      checks++;
      if (cap_r[1][c*CPLX_W +: CPLX_W] !== {64'h0, $realtobits(7.0 + real'(c))}) begin
        errors++;
        $display("FAIL row3_elem%0d: got %h expected %h", c, cap_r[1][c*CPLX_W +: CPLX_W], {64'h0, $realtobits(7.0 + real'(c))});
      end
    end
    checks++;
    if (cap_r[2] !== {384'h0, 64'h0, $realtobits(1.0)}) begin
      errors++;
      $display("FAIL row0_contents: got %h expected %h", cap_r[2], {384'h0, 64'h0, $realtobits(1.0)});
    end
  endtask

  task automatic test_serve_reads();
    int n;
    n = 11;
    raddr[0] = 2; raddr[1] = 0; raddr[2] = 3;
    for (int j = 3; j < n; j++) raddr[j] = $urandom_range(SIZE - 1);
    do_read(n);
    checks++;
    if (cap_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL read_idle: got row_valid=%b expected 0", cap_v[0]);
    end
    for (int j = 1; j <= n; j++) begin
      checks++;
      if (cap_v[j] !== 1'b1 || cap_a[j] !== AW'(raddr[j-1]) || cap_r[j] !== exp_row(raddr[j-1])) begin
        errors++;
        $display("FAIL read%0d: got v=%b a=%0d %h expected v=1 a=%0d %h", j, cap_v[j], cap_a[j], cap_r[j], raddr[j-1], exp_row(raddr[j-1]));
      end
    end
    checks++;
    if (cap_v[n+1] !== 1'b0 || cap_a[n+1] !== AW'(raddr[n-1]) || cap_r[n+1] !== exp_row(raddr[n-1])) begin
      errors++;
      $display("FAIL read_hold: got v=%b a=%0d expected v=0 a=%0d with row held", cap_v[n+1], cap_a[n+1], raddr[n-1]);
    end
    release_done();
    checks++;
    if (ld_ready !== 1'b1 || busy !== 1'b0 || row_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_release: got rdy=%b busy=%b rv=%b expected 1 0 0", ld_ready, busy, row_valid);
    end
  endtask

  task automatic test_diag_zero();
    int hs, st, rdy, dr, sa, zi;
    for (int it = 0; it < 3; it++) begin
      zi = (it == 0) ? 2 : (($urandom_range(2) == 0) ? -1 : $urandom_range(NEL - 1));
      fill_random(zi);
      if (it == 0) mdl[2] = {64'h8000_0000_0000_0000, 64'h0};
      feed(0, NEL, 1'b0, hs, st, rdy, dr, sa);
      checks++;
      if (hs !== NEL || st !== 1) begin
        errors++;
        $display("FAIL diag_load%0d: got hs=%0d starts=%0d expected %0d 1", it, hs, st, NEL);
      end
      checks++;
      if (dr !== ((first_zero_diag() < 0) ? -1 : first_zero_diag() + 1)) begin
        errors++;
        $display("FAIL diag_rise%0d: got %0d expected %0d", it, dr, (first_zero_diag() < 0) ? -1 : first_zero_diag() + 1);
      end
      check_all_rows("diag");
      checks++;
      if (diag_zero !== (first_zero_diag() >= 0)) begin
        errors++;
        $display("FAIL diag_sticky%0d: got %b expected %b", it, diag_zero, first_zero_diag() >= 0);
      end
      release_done();
      checks++;
      if (diag_zero !== 1'b0) begin
        errors++;
        $display("FAIL diag_clear%0d: got %b expected 0", it, diag_zero);
      end
    end
  endtask

  task automatic test_gapped_load();
    int hs, st, rdy, dr, sa;
    fill_random(-1);
    feed(0, NEL, 1'b1, hs, st, rdy, dr, sa);
    checks++;
    if (hs !== NEL || st !== 1 || sa !== NEL) begin
      errors++;
      $display("FAIL gap_handshake: got hs=%0d starts=%0d start_at=%0d expected %0d 1 %0d", hs, st, sa, NEL, NEL);
    end
    check_all_rows("gap");
    release_done();
  endtask

  task automatic test_flush();
    int hs, st, rdy, dr, sa;
    fill_random(-1);
    feed(0, 6, 1'b0, hs, st, rdy, dr, sa);
    checks++;
    if (busy !== 1'b1 || ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL partial_busy: got busy=%b rdy=%b expected 1 1", busy, ld_ready);
    end
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || ld_ready !== 1'b1 || start !== 1'b0) begin
      errors++;
      $display("FAIL flush_load: got busy=%b rdy=%b start=%b expected 0 1 0", busy, ld_ready, start);
    end
    fill_random(-1);
    feed(0, NEL, 1'b0, hs, st, rdy, dr, sa);
    checks++;
    if (hs !== NEL || st !== 1 || sa !== NEL) begin
      errors++;
      $display("FAIL reload_after_flush: got hs=%0d starts=%0d start_at=%0d expected %0d 1 %0d", hs, st, sa, NEL, NEL);
    end
    check_all_rows("fresh");
    release_done();

    fill_random(-1);
    feed(0, NEL - 1, 1'b0, hs, st, rdy, dr, sa);
    @(negedge clk); ld_valid = 1'b1; ld_data = mdl[NEL-1]; flush = 1'b1;
    @(negedge clk); ld_valid = 1'b0; flush = 1'b0;
    st = (start === 1'b1) ? 1 : 0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      if (start === 1'b1) st++;
    end
    checks++;
    if (st !== 0 || busy !== 1'b0 || ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_final: got starts=%0d busy=%b rdy=%b expected 0 0 1", st, busy, ld_ready);
    end

    fill_random(-1);
    feed(0, NEL, 1'b0, hs, st, rdy, dr, sa);
    @(negedge clk); row_addr_valid = 1'b1; row_addr = AW'($urandom_range(SIZE - 1)); flush = 1'b1;
    @(negedge clk); row_addr_valid = 1'b0; flush = 1'b0;
    checks++;
    if (row_valid !== 1'b0 || ld_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_serve: got rv=%b rdy=%b busy=%b expected 0 1 0", row_valid, ld_ready, busy);
    end
  endtask

  task automatic test_async_reset();
    int hs, st, rdy, dr, sa;
    fill_random(5);
    feed(0, NEL, 1'b0, hs, st, rdy, dr, sa);
    @(negedge clk); row_addr_valid = 1'b1; row_addr = 2'd1;
    @(negedge clk);
    checks++;
    if (row_valid !== 1'b1 || diag_zero !== 1'b1 || row !== exp_row(1)) begin
      errors++;
      $display("FAIL pre_reset: got rv=%b dz=%b expected 1 1 with row1", row_valid, diag_zero);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ld_ready, start, row_valid, diag_zero, busy} !== 5'b10000 || row !== '0 || row_addr_q !== '0) begin
      errors++;
      $display("FAIL async_reset: got rdy,start,rv,dz,busy=%b addr=%0d expected 10000 addr 0 row 0", {ld_ready, start, row_valid, diag_zero, busy}, row_addr_q);
    end
    @(negedge clk); rst_n = 1'b1; row_addr = 2'd3;
    @(negedge clk);
    checks++;
    if (row_valid !== 1'b0 || ld_ready !== 1'b1 || row !== '0) begin
      errors++;
      $display("FAIL post_reset_read: got rv=%b rdy=%b expected 0 1 with row 0", row_valid, ld_ready);
    end
    row_addr_valid = 1'b0;
    fill_random(-1);
    feed(0, NEL, 1'b0, hs, st, rdy, dr, sa);
    checks++;
    if (hs !== NEL || st !== 1) begin
      errors++;
      $display("FAIL post_reset_load: got hs=%0d starts=%0d expected %0d 1", hs, st, NEL);
    end
    check_all_rows("post_reset");
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_serve_reads();
    test_diag_zero();
    test_gapped_load();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
